// File: rtl/pp_pkg.sv
// Shared types, defaults and output rounding for the 2x polyphase
// interpolating FIR.
package pp_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_COEF_W = 16;
  localparam int DEF_NTAPS  = 8;

  typedef logic signed [DEF_DATA_W-1:0] sample_t;
  typedef logic signed [DEF_COEF_W-1:0] coef_t;

  localparam coef_t DEFAULT_COEF [DEF_NTAPS] = '{
    16'sd0, -16'sd1024, 16'sd0, 16'sd9216,
    16'sd16384, 16'sd9216, 16'sd0, -16'sd1024
  };

  typedef enum logic [1:0] {
    IDLE,
    PH0,
    PH1
  } state_t;

  // Round half up, drop the Q1.(cw-1) fraction, clamp to dw bits.
  function automatic logic signed [63:0] sat_round(
    input logic signed [63:0] acc,
    input int                 dw,
    input int                 cw
  );
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    r  = (acc + (64'sd1 <<< (cw - 2))) >>> (cw - 1);
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (r > hi) begin
      sat_round = hi;
    end else if (r < lo) begin
      sat_round = lo;
    end else begin
      sat_round = r;
    end
  endfunction

endpackage

// File: rtl/polyphase_interp_fir_mac.sv
// Combinational dot product of the delay line with one coefficient
// phase (even or odd taps).
module pp_phase_mac
  import pp_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int COEF_W = DEF_COEF_W,
  parameter int NTAPS  = DEF_NTAPS,
  parameter int PHASE  = 0,
  parameter logic signed [COEF_W-1:0] COEF [NTAPS] = DEFAULT_COEF
) (
  input  logic signed [DATA_W-1:0] d_i [NTAPS/2],
  output logic signed [DATA_W+COEF_W+$clog2(NTAPS/2)-1:0] acc_o
);

  localparam int PW = DATA_W + COEF_W;
  localparam int AW = PW + $clog2(NTAPS/2);

  always_comb begin
    logic signed [PW-1:0] prod;
    acc_o = '0;
    prod  = '0;
    for (int k = 0; k < NTAPS/2; k++) begin
      prod  = d_i[k] * COEF[2*k+PHASE];
      acc_o = acc_o + AW'(prod);
    end
  end

endmodule

// File: rtl/polyphase_interp_fir.sv
// 2x polyphase interpolating FIR: one input sample in, an even/odd
// output pair out on consecutive handshakes.
module polyphase_interp_fir
  import pp_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int COEF_W = DEF_COEF_W,
  parameter int NTAPS  = DEF_NTAPS,
  parameter logic signed [COEF_W-1:0] COEF [NTAPS] = DEFAULT_COEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic signed [DATA_W-1:0] s_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic signed [DATA_W-1:0] m_data,
  output logic                     m_phase
);

  localparam int NP = NTAPS / 2;
  localparam int AW = DATA_W + COEF_W + $clog2(NP);

  if (NTAPS % 2 != 0) begin : g_odd_taps
    $fatal(1, "polyphase_interp_fir: NTAPS must be even");
  end

  if (AW > 64) begin : g_acc_too_wide
    $fatal(1, "polyphase_interp_fir: accumulator exceeds 64 bits");
  end

  state_t state_q, state_d;

  logic signed [DATA_W-1:0] d_q [NP];
  logic signed [DATA_W-1:0] d_d [NP];
  logic signed [DATA_W-1:0] y_q, y_d;
  logic signed [DATA_W-1:0] y0, y1;
  logic signed [AW-1:0]     acc0, acc1;
  logic                     s_fire;

  assign s_ready = (state_q == IDLE) ||
                   (state_q == PH1 && m_ready);
  assign s_fire  = s_valid && s_ready;
  assign m_valid = (state_q != IDLE);
  assign m_phase = (state_q == PH1);
  assign m_data  = y_q;

  always_comb begin
    d_d = d_q;
    if (s_fire) begin
      d_d[0] = s_data;
      for (int i = 1; i < NP; i++) begin
        d_d[i] = d_q[i-1];
      end
    end
  end

  // Both phases see the freshly shifted line; phase 1 is taken a
  // cycle later when no shift can occur, so the snapshot matches.
  pp_phase_mac #(
    .DATA_W(DATA_W),
    .COEF_W(COEF_W),
    .NTAPS (NTAPS),
    .PHASE (0),
    .COEF  (COEF)
  ) u_mac0 (
    .d_i  (d_d),
    .acc_o(acc0)
  );

  pp_phase_mac #(
    .DATA_W(DATA_W),
    .COEF_W(COEF_W),
    .NTAPS (NTAPS),
    .PHASE (1),
    .COEF  (COEF)
  ) u_mac1 (
    .d_i  (d_d),
    .acc_o(acc1)
  );

  assign y0 = DATA_W'(sat_round(64'(acc0), DATA_W, COEF_W));
  assign y1 = DATA_W'(sat_round(64'(acc1), DATA_W, COEF_W));

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    unique case (state_q)
      IDLE: begin
        if (s_fire) begin
          state_d = PH0;
          y_d     = y0;
        end
      end
      PH0: begin
        if (m_ready) begin
          state_d = PH1;
          y_d     = y1;
        end
      end
      PH1: begin
        if (m_ready) begin
          if (s_valid) begin
            state_d = PH0;
            y_d     = y0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      y_q     <= '0;
      for (int i = 0; i < NP; i++) begin
        d_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      d_q     <= d_d;
    end
  end

endmodule

// File: tb/tb_polyphase_interp_fir.sv
// Directed bench for polyphase_interp_fir: impulse, DC, stall,
// saturation, reset and idle-gap vectors.
module tb_polyphase_interp_fir;

  logic               clk;
  logic               rst_n;
  logic               s_valid;
  logic               s_ready;
  logic signed [15:0] s_data;
  logic               m_valid;
  logic               m_ready;
  logic signed [15:0] m_data;
  logic               m_phase;

  logic               sat_s_ready;
  logic               sat_m_valid;
  logic signed [15:0] sat_m_data;
  logic               sat_m_phase;

  localparam logic signed [15:0] SAT_COEF [8] = '{default: 16'sd32767};
  localparam int H [8] = '{0, -1024, 0, 9216, 16384, 9216, 0, -1024};

  int n_chk;
  int n_fail;
  int hx [4];
  int od[$];
  int op[$];
  int sd[$];
  int sp[$];
  int e[$];

  polyphase_interp_fir dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data (s_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data (m_data),
    .m_phase(m_phase)
  );

  polyphase_interp_fir #(
    .COEF(SAT_COEF)
  ) dut_sat (
    .clk    (clk),
    .rst_n  (rst_n),
    .s_valid(s_valid),
    .s_ready(sat_s_ready),
    .s_data (s_data),
    .m_valid(sat_m_valid),
    .m_ready(m_ready),
    .m_data (sat_m_data),
    .m_phase(sat_m_phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      od.push_back(int'(m_data));
      op.push_back(int'(m_phase));
    end
    if (rst_n && sat_m_valid && m_ready) begin
      sd.push_back(int'(sat_m_data));
      sp.push_back(int'(sat_m_phase));
    end
  end

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int model_y(input int p);
    longint acc;
    acc = 0;
    for (int k = 0; k < 4; k++) begin
      acc += longint'(H[2*k+p]) * longint'(hx[k]);
    end
    acc = (acc + 64'sd16384) >>> 15;
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
    return int'(acc);
  endfunction

  task automatic mpush(input int x);
    for (int k = 3; k > 0; k--) hx[k] = hx[k-1];
    hx[0] = x;
  endtask

  task automatic mclear();
    for (int k = 0; k < 4; k++) hx[k] = 0;
  endtask

  task automatic qclear();
    od.delete();
    op.delete();
    sd.delete();
    sp.delete();
    e.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int x);
    bit fire;
    int n;
    s_valid = 1'b1;
    s_data  = 16'(x);
    n = 0;
    do begin
      @(negedge clk);
      fire = s_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!fire && n < 50);
    if (!fire) begin
      chk("send_timeout", 0, 1);
    end else begin
      mpush(x);
      e.push_back(model_y(0));
      e.push_back(model_y(1));
    end
    s_valid = 1'b0;
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, "_count"}, od.size(), e.size());
    for (int i = 0; i < od.size() && i < e.size(); i++) begin
      chk($sformatf("%s_data%0d", tag, i), od[i], e[i]);
      chk($sformatf("%s_ph%0d", tag, i), op[i], i % 2);
    end
  endtask

  task automatic run_impulse(input string tag);
    int imp [16];
    imp = '{0, -512, 0, 4608, 8192, 4608, 0, -512,
            0, 0, 0, 0, 0, 0, 0, 0};
    qclear();
    send(16384);
    repeat (7) send(0);
    idle(3);
    chk({tag, "_count"}, od.size(), 16);
    for (int i = 0; i < 16 && i < od.size(); i++) begin
      chk($sformatf("%s_data%0d", tag, i), od[i], imp[i]);
      chk($sformatf("%s_ph%0d", tag, i), op[i], i % 2);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc [16];
    int sr [16];
    int mv [16];
    int bad;
    int hold;

    n_chk   = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b1;
    mclear();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // reset state
    @(negedge clk);
    chk("rst_mvalid", int'(m_valid), 0);
    chk("rst_mdata", int'(m_data), 0);
    chk("rst_mphase", int'(m_phase), 0);
    chk("rst_sready", int'(s_ready), 1);
    @(posedge clk);
    #1;

    // 1: impulse
    run_impulse("imp");

    // 2: DC, s_valid held high
    qclear();
    dc = '{0, -512, 0, 4096, 8192, 8704, 8192, 8192,
           8192, 8192, 8192, 8192, 8192, 8192, 8192, 8192};
    s_valid = 1'b1;
    s_data  = 16'sd16384;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      sr[c] = int'(s_ready);
      mv[c] = int'(m_valid);
      if (c == 8) chk("dc_sready_sat", int'(sat_s_ready), 1);
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    idle(2);
    repeat (8) mpush(16384);
    chk("dc_count", od.size(), 16);
    for (int i = 0; i < 16 && i < od.size(); i++) begin
      chk($sformatf("dc_data%0d", i), od[i], dc[i]);
    end
    chk("dc_sready8", sr[8], 1);
    chk("dc_sready9", sr[9], 0);
    chk("dc_sready10", sr[10], 1);
    chk("dc_sready11", sr[11], 0);
    chk("dc_mvalid0", mv[0], 0);
    bad = 0;
    for (int c = 1; c < 16; c++) if (mv[c] != 1) bad++;
    chk("dc_mvalid_held", bad, 0);

    // 3: backpressure in PH0
    qclear();
    send(1000);
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_data  = -16'sd2500;
    hold = e[0];
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("bp_data%0d", c), int'(m_data), hold);
      chk($sformatf("bp_phase%0d", c), int'(m_phase), 0);
      chk($sformatf("bp_sready%0d", c), int'(s_ready), 0);
      chk($sformatf("bp_mvalid%0d", c), int'(m_valid), 1);
      @(posedge clk);
      #1;
    end
    m_ready = 1'b1;
    send(-2500);
    send(31000);
    idle(3);
    cmp_model("bp");

    // 4: saturation on the all-32767 instance
    qclear();
    repeat (4) send(32767);
    idle(3);
    chk("satp_count", sd.size(), 8);
    if (sd.size() >= 2) begin
      chk("satp_even", sd[sd.size()-2], 32767);
      chk("satp_odd", sd[sd.size()-1], 32767);
      chk("satp_ph", sp[sp.size()-1], 1);
    end
    cmp_model("satp_main");
    qclear();
    repeat (4) send(-32768);
    idle(3);
    chk("satn_count", sd.size(), 8);
    if (sd.size() >= 2) begin
      chk("satn_even", sd[sd.size()-2], -32768);
      chk("satn_odd", sd[sd.size()-1], -32768);
    end
    cmp_model("satn_main");

    // 5: reset while PH0 is pending with history
    send(5000);
    rst_n = 1'b0;
    #2;
    chk("mrst_mvalid", int'(m_valid), 0);
    chk("mrst_mdata", int'(m_data), 0);
    chk("mrst_mphase", int'(m_phase), 0);
    mclear();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_impulse("mrst_imp");

    // 6: isolated inputs with idle gaps
    qclear();
    foreach (dc[i]) dc[i] = 0;
    dc[0] = 1200;
    dc[1] = -3000;
    dc[2] = 7777;
    dc[3] = -20000;
    dc[4] = 300;
    for (int j = 0; j < 5; j++) begin
      send(dc[j]);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk($sformatf("gap_mvalid%0d", j), int'(m_valid), 0);
      chk($sformatf("gap_sready%0d", j), int'(s_ready), 1);
      @(posedge clk);
      #1;
      idle(1);
    end
    cmp_model("gap");

    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end

endmodule
